neuron_mac_ctrl_act: RTL and testbench
======================================

Name: neuron_mac_ctrl_act

Overview:
- Per-neuron helper block for one node of a fully connected layer.
- Contains two independent functions:
  - MAC iteration counter: counts MAC-step acknowledge pulses and raises a sticky done flag once every input of the neuron has been accumulated.
  - Activation unit: purely combinational; maps the signed fixed-point pre-activation z to the output a.
- Sits between the layer's MAC/add pipeline and its output register.

Parameters:
- N_INPUTS, 2, number of MAC steps (neuron fan-in) before done asserts; must be >= 1.
- DATA_W, 8, width of the signed z and a datapath.
- FRAC_BITS, 4, fractional bits of the two's-complement fixed-point format (Q4.4 at defaults; 1.0 = 16).

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ack  input  1  one-cycle pulse from the MAC unit, one per completed multiply-accumulate step.
- ack_mac  output  1  registered, sticky "all inputs accumulated" flag; the parent uses it to mask further MAC requests.
- count  output  $clog2(N_INPUTS+1)  current number of accepted ack pulses.
- z_value  input  DATA_W  signed pre-activation value.
- a  output  DATA_W  signed activation result, combinational from z_value.

Behaviour:
Counter (synchronous, rising edge of clk):
- Reset: when rst=1, count<=0 and ack_mac<=0. Reset has priority over ack in the same cycle.
- Counting: when rst=0, ack=1 and ack_mac=0, count<=count+1.
- Done: on the same edge that count goes to N_INPUTS, ack_mac<=1. ack_mac is therefore visible in the cycle after the edge that sampled the N-th ack.
- After done: ack_mac stays 1 and count holds at N_INPUTS until rst. Further ack pulses are ignored, so there is no wrap-around.
- Back-to-back pulses: ack high on consecutive cycles counts once per cycle.
- ack=0 holds count.
- Mid-operation reset: a partially accumulated count is discarded and counting restarts from 0.
- Outputs are defined (0) from the first reset edge onward.

Activation (combinational, no latency):
- Default function is hard sigmoid in fixed point:
  - a = clamp((z_value >>> 2) + HALF, 0, ONE).
  - HALF = 1 << (FRAC_BITS-1); ONE = 1 << FRAC_BITS.
  - At defaults: HALF = 8, ONE = 16, so the output range is 0..16 (0.0..1.0).
- Shift is arithmetic (sign-preserving), truncating toward minus infinity.
- Compute the intermediate sum in DATA_W+1 bits so it never overflows before clamping.
- Reference points at defaults:
  - z <= -32 gives a=0.
  - z = 0 gives a=8.
  - z >= 32 gives a=16.
  - z = -128 gives 0; z = 127 gives 16.
- a is independent of clk and rst and follows z_value within the same cycle.

Optional Feature:
- Macro: NN_ACT_RELU_EN.
- Defined: the activation is ReLU.
  - a = (z_value < 0) ? 0 : z_value; no upper clamp.
  - Examples: z=-5 gives 0; z=40 gives 40; z=127 gives 127.
- Not defined: hard sigmoid as specified above.
- The counter is identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with ack=1 -> count=0, ack_mac=0 throughout.
- Single pulses: release rst, pulse ack at cycles 3 and 7 -> count=1 after the first pulse with ack_mac=0; count=2 after the second, with ack_mac=1 on the following cycle and held.
- Saturation: ack held high for 5 cycles (N_INPUTS=2) -> count stops at 2 and ack_mac stays 1; then rst=1 for one cycle -> count=0, ack_mac=0 at the next edge.
- Priority and mid-count reset: rst and ack both 1 in the same cycle -> count stays 0; reset after a single ack -> count returns to 0 and two new acks are again required.
- Hard sigmoid sweep (macro undefined): z = -128, -33, -32, -4, 0, 5, 31, 32, 127 -> a = 0, 0, 0, 7, 8, 9, 15, 16, 16.
- ReLU sweep (NN_ACT_RELU_EN defined): z = -128, -1, 0, 1, 127 -> a = 0, 0, 0, 1, 127; counter test 2 gives identical results.

Source files
------------

// File: rtl/neuron_mac_ctrl_act.sv
// -----------------------------------------------------------------------------
// neuron_mac_ctrl_act
//
// Per-neuron helper for one node of a fully connected layer. It holds two
// independent functions:
//   1. MAC iteration counter. It counts the MAC-step acknowledge pulses and
//      raises a sticky done flag once all N_INPUTS products have been
//      accumulated. After that flag is set the count holds at N_INPUTS and
//      further pulses are ignored until reset, so the count never wraps.
//   2. Activation unit. This is purely combinational. It maps the signed
//      fixed-point pre-activation z_value to the activation a.
//
// Build option (macro NN_ACT_RELU_EN):
//   undefined : hard sigmoid,
//               a = clamp((z >>> 2) + HALF, 0, ONE),
//               where HALF = 1 << (FRAC_BITS-1) and ONE = 1 << FRAC_BITS.
//   defined   : ReLU, a = (z < 0) ? 0 : z, with no upper clamp.
//   The counter is the same in both builds.
//
// Parameters:
//   N_INPUTS  : neuron fan-in, the number of acks before done (>= 1).
//   DATA_W    : width of the signed z_value / a datapath.
//   FRAC_BITS : fractional bits of the two's-complement fixed-point format.
//
// Ports:
//   clk      in   system clock. All state changes happen on the rising edge.
//   rst      in   synchronous, active-high reset. It wins over ack.
//   ack      in   one-cycle pulse for each completed multiply-accumulate step.
//   ack_mac  out  registered, sticky "all inputs accumulated" flag.
//   count    out  number of accepted ack pulses, 0..N_INPUTS.
//   z_value  in   signed pre-activation value.
//   a        out  signed activation result. It is combinational from z_value.
// -----------------------------------------------------------------------------
module neuron_mac_ctrl_act #(
  parameter int N_INPUTS  = 2,
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  localparam int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ack,
  output logic                     ack_mac,
  output logic [CNT_W-1:0]         count,
  input  logic signed [DATA_W-1:0] z_value,
  output logic signed [DATA_W-1:0] a
);

  // ---------------------------------------------------------------------------
  // MAC iteration counter
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] LAST_BEFORE_DONE = CNT_W'(N_INPUTS - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_mac_q, ack_mac_d;

  // NOTE: every signal assigned in always_comb gets a default value first.
  // This keeps a path that does not assign it from inferring a latch.
  always_comb begin
    count_d   = count_q;
    ack_mac_d = ack_mac_q;
    // Once done is set it gates further pulses. That is what makes
    // count saturate at N_INPUTS instead of wrapping.
    if (ack && !ack_mac_q) begin
      count_d = count_q + CNT_W'(1);
      // Done rises on the same edge that count reaches N_INPUTS.
      if (count_q == LAST_BEFORE_DONE) begin
        ack_mac_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // Every flop then samples the value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      ack_mac_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      ack_mac_q <= ack_mac_d;
    end
  end

  assign count   = count_q;
  assign ack_mac = ack_mac_q;

  // ---------------------------------------------------------------------------
  // Activation unit (combinational)
  // ---------------------------------------------------------------------------
`ifdef NN_ACT_RELU_EN

  // ReLU: the sign bit alone decides between zero and pass-through.
  always_comb begin
    a = z_value;
    if (z_value[DATA_W-1]) begin
      a = '0;
    end
  end

`else

  localparam logic signed [DATA_W:0] HALF_S = (DATA_W + 1)'(1 << (FRAC_BITS - 1));
  localparam logic signed [DATA_W:0] ONE_S  = (DATA_W + 1)'(1 << FRAC_BITS);

  logic signed [DATA_W:0] z_ext;
  logic signed [DATA_W:0] z_shr;
  logic signed [DATA_W:0] sum;

  // The sum is computed one bit wider than the datapath, so adding HALF
  // to the shifted value cannot overflow before the clamp.
  assign z_ext = {z_value[DATA_W-1], z_value};
  // Arithmetic shift. It truncates toward minus infinity, e.g. -5 >>> 2 = -2.
  assign z_shr = z_ext >>> 2;
  assign sum   = z_shr + HALF_S;

  always_comb begin
    a = sum[DATA_W-1:0];
    if (sum < 0) begin
      a = '0;
    end else if (sum > ONE_S) begin
      a = ONE_S[DATA_W-1:0];
    end
  end

`endif

endmodule

// File: tb/tb_neuron_mac_ctrl_act.sv
// -----------------------------------------------------------------------------
// Self-checking bench for neuron_mac_ctrl_act.
//
// The counter is compared each cycle against an event-level model. The model
// has three rules:
//   - reset clears the model;
//   - an ack counts only while the model is not done;
//   - done is set when the tally reaches N.
//
// The activation is compared against the fixed-point formula, evaluated with
// integer arithmetic. The stimulus is a directed sequence followed by random
// rst/ack and random z_value.
// -----------------------------------------------------------------------------
module tb_neuron_mac_ctrl_act;

  localparam int N      = 2;
  localparam int DW     = 8;
  localparam int FRAC   = 4;
  localparam int CNT_W  = $clog2(N + 1);

  logic                 clk;
  logic                 rst;
  logic                 ack;
  logic                 ack_mac;
  logic [CNT_W-1:0]     count;
  logic signed [DW-1:0] z_value;
  logic signed [DW-1:0] a;

  int vectors     = 0;
  int miscompares = 0;

  // Reference-model state for the counter.
  int m_count = 0;
  bit m_done  = 1'b0;

  neuron_mac_ctrl_act #(
    .N_INPUTS (N),
    .DATA_W   (DW),
    .FRAC_BITS(FRAC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ack    (ack),
    .ack_mac(ack_mac),
    .count  (count),
    .z_value(z_value),
    .a      (a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Integer reference for the activation, taken straight from the formula.
  function automatic int act_ref(input int z);
    int q;
    int v;
`ifdef NN_ACT_RELU_EN
    v = (z < 0) ? 0 : z;
`else
    // Floor division by 4 equals an arithmetic shift right by 2.
    q = (z >= 0) ? (z / 4) : -((-z + 3) / 4);
    v = q + (1 << (FRAC - 1));
    if (v < 0) v = 0;
    if (v > (1 << FRAC)) v = (1 << FRAC);
`endif
    return v;
  endfunction

  // Drive one cycle. Inputs change on the falling edge; the model is updated
  // at the rising edge; outputs are sampled 1 time unit after that edge.
  task automatic cycle(input bit r, input bit k, input string tag);
    @(negedge clk);
    rst = r;
    ack = k;
    @(posedge clk);
    if (r) begin
      m_count = 0;
      m_done  = 1'b0;
    end else if (k && !m_done) begin
      m_count++;
      if (m_count == N) m_done = 1'b1;
    end
    #1;
    check({tag, ".count"},   32'(count),   32'(m_count));
    check({tag, ".ack_mac"}, 32'(ack_mac), 32'(m_done));
  endtask

  task automatic check_act(input int z, input int exp, input string tag);
    z_value = DW'(z);
    #1;
    check(tag, 32'(a), 32'(exp));
  endtask

`ifdef NN_ACT_RELU_EN
  int sweep_z[5] = '{-128, -1, 0, 1, 127};
  int sweep_a[5] = '{0, 0, 0, 1, 127};
`else
  int sweep_z[9] = '{-128, -33, -32, -4, 0, 5, 31, 32, 127};
  int sweep_a[9] = '{0, 0, 0, 7, 8, 9, 15, 16, 16};
`endif

  initial begin
    rst     = 1'b1;
    ack     = 1'b1;
    z_value = '0;

    // Reset for 2 cycles with ack high: the counter must stay cleared.
    cycle(1, 1, "reset0");
    cycle(1, 1, "reset1");

    // Single pulses at cycles 3 and 7.
    cycle(0, 1, "pulse1");
    for (int i = 0; i < 3; i++) cycle(0, 0, "idle1");
    cycle(0, 1, "pulse2");
    for (int i = 0; i < 3; i++) cycle(0, 0, "held");

    // Saturation: ack held high for 5 cycles.
    for (int i = 0; i < 5; i++) cycle(0, 1, "sat");
    cycle(1, 0, "sat_rst");

    // Priority: rst and ack high in the same cycle.
    cycle(1, 1, "prio");

    // Mid-count reset: two new acks are required after it.
    cycle(0, 1, "mid_ack");
    cycle(1, 0, "mid_rst");
    cycle(0, 1, "re_ack1");
    cycle(0, 0, "re_idle");
    cycle(0, 1, "re_ack2");
    cycle(0, 1, "re_extra");

    // Random rst/ack traffic with an occasional reset.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 15) == 0), $urandom_range(0, 1), "rand_cnt");
    end

    // Directed activation sweep.
    foreach (sweep_z[i]) check_act(sweep_z[i], sweep_a[i], "act_sweep");

    // Random activation values, checked against the integer reference.
    for (int i = 0; i < 200; i++) begin
      int z;
      z = int'($signed(DW'($urandom)));
      check_act(z, act_ref(z), "act_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
